// File: rtl/gray_monitor.sv
// Gray-code sequence monitor for the 3-bit upstream counter.
// Tracks legal advances, counts wraps and latches the first fault.
module gray_monitor (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] GrayIn,
  input  logic       OvfIn,
  output logic [2:0] Bin,
  output logic       Step,
  output logic [7:0] Wraps,
  output logic       Err,
  output logic [1:0] ErrCode,
  output logic       Tracking
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_prev;
  logic [2:0] w_prev_nxt;
  logic [2:0] r_bin;
  logic [2:0] w_bin_nxt;
  logic       r_step;
  logic       w_step_nxt;
  logic [7:0] r_wraps;
  logic [7:0] w_wraps_nxt;
  logic       r_err;
  logic       w_err_nxt;
  logic [1:0] r_code;
  logic [1:0] w_code_nxt;

  logic [2:0] w_succ;
  logic       w_hold;
  logic       w_adv;
  logic       w_wrap;
  logic       w_illegal;
  logic [7:0] w_wraps_upd;
  logic       w_ovf_exp;
  logic       w_mismatch;

  function automatic logic [2:0] gray_succ(
    input logic [2:0] g
  );
    logic [2:0] s;
    case (g)
      3'b000:  s = 3'b001;
      3'b001:  s = 3'b011;
      3'b011:  s = 3'b010;
      3'b010:  s = 3'b110;
      3'b110:  s = 3'b111;
      3'b111:  s = 3'b101;
      3'b101:  s = 3'b100;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] gray2bin(
    input logic [2:0] g
  );
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  always_comb begin
    w_succ      = gray_succ(r_prev);
    w_hold      = (GrayIn == r_prev);
    w_adv       = (GrayIn == w_succ);
    w_wrap      = w_adv && (r_prev == 3'b100);
    w_illegal   = !w_hold && !w_adv;
    w_wraps_upd = r_wraps;
    if (w_wrap && (r_wraps != 8'hFF))
      w_wraps_upd = r_wraps + 8'd1;
    // upstream flag must agree with the count as it stands after this edge
    w_ovf_exp   = (w_wraps_upd != 8'd0);
    w_mismatch  = (OvfIn != w_ovf_exp);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_bin_nxt   = r_bin;
    w_step_nxt  = 1'b0;
    w_wraps_nxt = r_wraps;
    w_err_nxt   = r_err;
    w_code_nxt  = r_code;
    case (r_state)
      IDLE: begin
        if (GrayIn == 3'b000 && !OvfIn) begin
          w_state_nxt = TRACK;
          w_prev_nxt  = 3'b000;
          w_bin_nxt   = 3'b000;
        end
      end
      TRACK: begin
        if (w_illegal || w_mismatch) begin
          w_state_nxt = ERROR;
          w_err_nxt   = 1'b1;
          w_code_nxt  = {w_mismatch, w_illegal};
        end else if (w_adv) begin
          w_prev_nxt  = GrayIn;
          w_bin_nxt   = gray2bin(GrayIn);
          w_step_nxt  = 1'b1;
          w_wraps_nxt = w_wraps_upd;
        end
      end
      ERROR: begin
        w_state_nxt = ERROR;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_prev  <= 3'b000;
      r_bin   <= 3'b000;
      r_step  <= 1'b0;
      r_wraps <= 8'd0;
      r_err   <= 1'b0;
      r_code  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
      r_bin   <= w_bin_nxt;
      r_step  <= w_step_nxt;
      r_wraps <= w_wraps_nxt;
      r_err   <= w_err_nxt;
      r_code  <= w_code_nxt;
    end
  end

  assign Bin      = r_bin;
  assign Step     = r_step;
  assign Wraps    = r_wraps;
  assign Err      = r_err;
  assign ErrCode  = r_code;
  assign Tracking = (r_state == TRACK);

endmodule

// File: tb/tb_gray_monitor.sv
// Directed vector bench for gray_monitor.
// Table rows plus hand sequences for wrap, saturation and mismatch cases.
module tb_gray_monitor;

  logic       Clk;
  logic       Reset;
  logic [2:0] GrayIn;
  logic       OvfIn;
  logic [2:0] Bin;
  logic       Step;
  logic [7:0] Wraps;
  logic       Err;
  logic [1:0] ErrCode;
  logic       Tracking;

  int n_chk = 0;
  int n_err = 0;

  gray_monitor dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .GrayIn   (GrayIn),
    .OvfIn    (OvfIn),
    .Bin      (Bin),
    .Step     (Step),
    .Wraps    (Wraps),
    .Err      (Err),
    .ErrCode  (ErrCode),
    .Tracking (Tracking)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [2:0] g;
    logic       ovf;
    logic [2:0] bin;
    logic       step;
    logic [7:0] wraps;
    logic       err;
    logic [1:0] code;
    logic       trk;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic rst, input logic [2:0] g, input logic ovf,
    input logic [2:0] bin, input logic step, input logic [7:0] wraps,
    input logic err, input logic [1:0] code, input logic trk
  );
    vec_t v;
    v.rst = rst; v.g = g; v.ovf = ovf;
    v.bin = bin; v.step = step; v.wraps = wraps;
    v.err = err; v.code = code; v.trk = trk;
    vq.push_back(v);
  endtask

  task automatic drive(
    input logic rst, input logic [2:0] g, input logic ovf
  );
    @(negedge Clk);
    Reset  = rst;
    GrayIn = g;
    OvfIn  = ovf;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(
    input string name, input logic [7:0] got, input logic [7:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  initial begin
    Reset  = 1'b1;
    GrayIn = 3'b000;
    OvfIn  = 1'b0;

    // full sequence with wrap
    add(1, 3'b000, 0, 3'd0, 0, 8'd0, 0, 2'b00, 0);
    add(0, 3'b000, 0, 3'd0, 0, 8'd0, 0, 2'b00, 1);
    add(0, 3'b001, 0, 3'd1, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b011, 0, 3'd2, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b010, 0, 3'd3, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b110, 0, 3'd4, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b111, 0, 3'd5, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b101, 0, 3'd6, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b100, 0, 3'd7, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b000, 1, 3'd0, 1, 8'd1, 0, 2'b00, 1);
    // hold at 011 then advance
    add(0, 3'b001, 1, 3'd1, 1, 8'd1, 0, 2'b00, 1);
    add(0, 3'b011, 1, 3'd2, 1, 8'd1, 0, 2'b00, 1);
    for (int i = 0; i < 5; i++)
      add(0, 3'b011, 1, 3'd2, 0, 8'd1, 0, 2'b00, 1);
    add(0, 3'b010, 1, 3'd3, 1, 8'd1, 0, 2'b00, 1);
    add(0, 3'b010, 1, 3'd3, 0, 8'd1, 0, 2'b00, 1);
    // reset mid-track, then illegal jump 001->010
    add(1, 3'b001, 0, 3'd0, 0, 8'd0, 0, 2'b00, 0);
    add(0, 3'b000, 0, 3'd0, 0, 8'd0, 0, 2'b00, 1);
    add(0, 3'b001, 0, 3'd1, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b010, 0, 3'd1, 0, 8'd0, 1, 2'b01, 0);
    add(0, 3'b011, 0, 3'd1, 0, 8'd0, 1, 2'b01, 0);
    add(0, 3'b011, 1, 3'd1, 0, 8'd0, 1, 2'b01, 0);
    // reset while in error
    add(1, 3'b011, 1, 3'd0, 0, 8'd0, 0, 2'b00, 0);
    // idle ignores non-start samples
    add(0, 3'b001, 0, 3'd0, 0, 8'd0, 0, 2'b00, 0);
    add(0, 3'b000, 1, 3'd0, 0, 8'd0, 0, 2'b00, 0);
    add(0, 3'b000, 0, 3'd0, 0, 8'd0, 0, 2'b00, 1);
    // overflow before any wrap, at 011
    add(0, 3'b001, 0, 3'd1, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b011, 0, 3'd2, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b011, 1, 3'd2, 0, 8'd0, 1, 2'b10, 0);
    add(1, 3'b000, 0, 3'd0, 0, 8'd0, 0, 2'b00, 0);
    // illegal and mismatch together
    add(0, 3'b000, 0, 3'd0, 0, 8'd0, 0, 2'b00, 1);
    add(0, 3'b011, 1, 3'd0, 0, 8'd0, 1, 2'b11, 0);
    add(1, 3'b000, 0, 3'd0, 0, 8'd0, 0, 2'b00, 0);
    // reset at Bin=101
    add(0, 3'b000, 0, 3'd0, 0, 8'd0, 0, 2'b00, 1);
    add(0, 3'b001, 0, 3'd1, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b011, 0, 3'd2, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b010, 0, 3'd3, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b110, 0, 3'd4, 1, 8'd0, 0, 2'b00, 1);
    add(0, 3'b111, 0, 3'd5, 1, 8'd0, 0, 2'b00, 1);
    add(1, 3'b101, 0, 3'd0, 0, 8'd0, 0, 2'b00, 0);
    add(0, 3'b000, 0, 3'd0, 0, 8'd0, 0, 2'b00, 1);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].g, vq[i].ovf);
      n_chk++;
      if (Bin !== vq[i].bin || Step !== vq[i].step ||
          Wraps !== vq[i].wraps || Err !== vq[i].err ||
          ErrCode !== vq[i].code || Tracking !== vq[i].trk) begin
        n_err++;
        $display("FAIL vec%0d: got bin=%0d step=%0b wraps=%0d err=%0b code=%b trk=%0b required bin=%0d step=%0b wraps=%0d err=%0b code=%b trk=%0b",
          i, Bin, Step, Wraps, Err, ErrCode, Tracking,
          vq[i].bin, vq[i].step, vq[i].wraps, vq[i].err,
          vq[i].code, vq[i].trk);
      end
    end

    // wrap with OvfIn low is a mismatch
    drive(1, 3'b000, 0);
    drive(0, 3'b000, 0);
    drive(0, 3'b001, 0);
    drive(0, 3'b011, 0);
    drive(0, 3'b010, 0);
    drive(0, 3'b110, 0);
    drive(0, 3'b111, 0);
    drive(0, 3'b101, 0);
    drive(0, 3'b100, 0);
    chk("pre_wrap_bin", {5'd0, Bin}, 8'd7);
    drive(0, 3'b000, 0);
    chk("wrap_noovf_err", {7'd0, Err}, 8'd1);
    chk("wrap_noovf_code", {6'd0, ErrCode}, 8'd2);
    chk("wrap_noovf_trk", {7'd0, Tracking}, 8'd0);

    // 260 wraps with correct OvfIn: count saturates
    drive(1, 3'b000, 0);
    drive(0, 3'b000, 0);
    for (int w = 0; w < 260; w++) begin
      logic [2:0] seq [7];
      int exp_w;
      seq = '{3'b001, 3'b011, 3'b010, 3'b110,
              3'b111, 3'b101, 3'b100};
      for (int k = 0; k < 7; k++)
        drive(0, seq[k], (w > 0));
      drive(0, 3'b000, 1);
      exp_w = (w + 1 > 255) ? 255 : w + 1;
      chk($sformatf("wraps_%0d", w + 1), Wraps, exp_w[7:0]);
    end
    chk("sat_err", {7'd0, Err}, 8'd0);
    chk("sat_trk", {7'd0, Tracking}, 8'd1);
    chk("sat_step", {7'd0, Step}, 8'd1);
    drive(0, 3'b000, 1);
    chk("sat_hold", Wraps, 8'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
